// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, issues req/ack word fetches and buffers
// returned instructions in a 2-entry queue feeding the IF/ID register.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } entry_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    entry_t      queue_q [2];
    entry_t      queue_d [2];

    logic        consume;
    logic [1:0]  count_pop;
    logic        push;
    logic        issue;
    logic [31:0] issue_addr;

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = req_addr_q;

    // A redirect marks the instruction presented this cycle as wrong-path.
    assign if_inst = (count_q != 2'd0 && !redirect_valid) ? queue_q[0].inst : NOP;
    assign if_pc4  = (count_q != 2'd0 && !redirect_valid) ? queue_q[0].pc4  : 32'h0;

    assign consume   = (count_q != 2'd0) && !stall && !redirect_valid;
    assign count_pop = count_q - {1'b0, consume};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        count_d    = count_pop;
        push       = 1'b0;
        issue      = 1'b0;
        issue_addr = pc_q;

        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    count_d    = 2'd0;
                    issue      = 1'b1;
                    issue_addr = redirect_pc;
                end else if (count_pop < 2'd2) begin
                    issue = 1'b1;
                end
            end
            BUSY: begin
                if (redirect_valid) begin
                    count_d = 2'd0;
                    if (imem_ack) begin
                        issue      = 1'b1;
                        issue_addr = redirect_pc;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    push    = 1'b1;
                    count_d = count_pop + 2'd1;
                    if (count_pop + 2'd1 < 2'd2) issue = 1'b1;
                    else                         state_d = IDLE;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        issue      = 1'b1;
                        issue_addr = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (imem_ack) begin
                    issue = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            req_addr_d = issue_addr;
            pc_d       = issue_addr + 32'd4;
            state_d    = BUSY;
        end

        queue_d = queue_q;
        if (consume) queue_d[0] = queue_q[1];
        if (push)    queue_d[count_pop[0]] = '{pc4: req_addr_q + 32'd4, inst: imem_rdata};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count_q gates every read of it.
    always_ff @(posedge clk) begin
        queue_q <= queue_d;
    end

    always_ff @(posedge clk) begin
        if (clrn) assert (!(push && count_pop == 2'd2));
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-configurable memory
// model and a scoreboard of the expected in-order instruction stream.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        clrn;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_pres = 0;
    int   mem_wait = 0;
    int   wait_cnt;
    exp_t sb_q[$];

    instruction_fetch dut (
        .clk           (clk),
        .clrn          (clrn),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_pc4        (if_pc4),
        .if_inst       (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks after mem_wait extra cycles of a held request.
    assign imem_ack   = imem_req && (wait_cnt >= mem_wait);
    assign imem_rdata = imem_addr | 32'hA000_0000;

    always @(posedge clk or negedge clrn) begin
        if (!clrn)                      wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        sb_q.delete();
        for (int k = 0; k < 48; k++) begin
            logic [31:0] a;
            a = start + 32'(4 * k);
            sb_q.push_back('{pc4: a + 32'd4, inst: a | 32'hA000_0000});
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] addr, input int budget);
        int found = 0;
        for (int i = 0; i < budget; i++) begin
            if (imem_req && imem_addr == addr) begin
                found = 1;
                break;
            end
            next_cycle();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Every presented instruction consumed by IF/ID must be the next expected one.
    always @(negedge clk) begin
        if (clrn && !stall && !redirect_valid && if_inst !== 32'h0) begin
            exp_t e;
            e = (sb_q.size() != 0) ? sb_q.pop_front() : '{pc4: 32'h0, inst: 32'h0};
            check("sb_pc4", if_pc4, e.pc4);
            check("sb_inst", if_inst, e.inst);
            n_pres++;
        end
    end

    initial begin
        logic [31:0] held;
        int          seen;

        clrn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        sb_restart(32'h0);
        #3;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_pc4", if_pc4, 32'h0);

        // Zero-wait stream from RESET_PC.
        @(posedge clk); #2; clrn = 1'b1;
        next_cycle();
        check("c1_req", 32'(imem_req), 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        next_cycle();
        check("c2_pc4", if_pc4, 32'h4);
        check("c2_inst", if_inst, 32'hA000_0000);
        next_cycle();
        check("c3_pc4", if_pc4, 32'h8);
        repeat (4) next_cycle();

        // Stall for 4 cycles: outputs frozen, request drops once queue is full.
        stall = 1'b1;
        #1 held = if_pc4;
        next_cycle();
        check("stall_req_low", 32'(imem_req), 32'd0);
        next_cycle();
        next_cycle();
        check("stall_held", if_pc4, held);
        check("stall_req_low2", 32'(imem_req), 32'd0);
        next_cycle();
        stall = 1'b0;
        repeat (3) next_cycle();

        // Async reset mid-request with one queued entry, then latency-3 memory.
        clrn = 1'b0; mem_wait = 2;
        sb_restart(32'h0);
        #1;
        check("mrst_req", 32'(imem_req), 32'd0);
        check("mrst_inst", if_inst, 32'h0);
        check("mrst_pc4", if_pc4, 32'h0);
        next_cycle();
        clrn = 1'b1;
        next_cycle();
        check("mrst_restart_addr", imem_addr, 32'h0);
        wait_addr("wait_addr8", 32'h8, 20);
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        sb_restart(32'h100);
        #1 check("redir_bubble", if_inst, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        check("drop_hold_addr", imem_addr, 32'h8);
        wait_addr("wait_addr100", 32'h100, 10);
        seen = 0;
        for (int i = 0; i < 12 && seen == 0; i++) begin
            if (if_inst !== 32'h0) seen = 1;
            else next_cycle();
        end
        check("first_pc4_after_redir", if_pc4, 32'h104);

        // Redirect coinciding with an ack: no DROP, target issued next cycle.
        mem_wait = 0;
        repeat (4) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        sb_restart(32'h200);
        #1 check("redir_ack_bubble", if_inst, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        check("redir_ack_addr", imem_addr, 32'h200);
        check("redir_ack_req", 32'(imem_req), 32'd1);
        repeat (3) next_cycle();

        // Redirect beats stall with a full queue.
        stall = 1'b1;
        repeat (2) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        sb_restart(32'h300);
        #1;
        check("redir_stall_inst", if_inst, 32'h0);
        check("redir_stall_pc4", if_pc4, 32'h0);
        check("redir_stall_idle", 32'(imem_req), 32'd0);
        next_cycle();
        redirect_valid = 1'b0; stall = 1'b0;
        check("redir_stall_addr", imem_addr, 32'h300);
        check("redir_stall_req", 32'(imem_req), 32'd1);
        repeat (3) next_cycle();

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        sb_restart(32'hFFFF_FFFC);
        next_cycle();
        redirect_valid = 1'b0;
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        check("wrap_addr_zero", imem_addr, 32'h0);
        check("wrap_pc4", if_pc4, 32'h0);
        check("wrap_inst", if_inst, 32'hFFFF_FFFC);
        repeat (3) next_cycle();

        check("presented_any", 32'(n_pres > 20), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage that produces the `if_pc4`/`if_inst` pair consumed by the IF/ID pipeline register. It sits between the instruction memory and IF/ID and owns the program counter. It issues word fetches over a req/ack memory handshake and buffers returned instructions in a 2-entry queue. It honours the same `stall` that freezes IF/ID and applies taken branch/jump redirects from ID, discarding wrong-path fetches. No delay slot: the instruction presented during a redirect cycle is wrong-path.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `NOP`, 32'h0000_0000, bubble instruction driven when nothing valid.
- `clk`  in  1  clock, rising edge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hazard stall; same signal that holds IF/ID.
- `redirect_valid`  in  1  taken branch/jump this cycle (single-cycle pulse or level).
- `redirect_pc`  in  32  redirect target, word aligned.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, held constant while `imem_req`=1.
- `imem_ack`  in  1  response strobe, meaningful only while `imem_req`=1.
- `imem_rdata`  in  32  instruction, valid with `imem_ack`.
- `if_pc4`  out  32  PC+4 of presented instruction.
- `if_inst`  out  32  presented instruction.

## Operation
- Registers: `pc` (next address to request), `req_addr`, a 2-entry queue of {pc4, inst} with `count` 0..2, and FSM `state`.
- States: IDLE (no request outstanding), BUSY (request outstanding, response kept), DROP (request outstanding, response discarded).
- Outputs: `imem_req` = (state != IDLE); `imem_addr` = `req_addr`.
- `if_inst`/`if_pc4` = queue head when count != 0 and `redirect_valid`=0; otherwise `NOP`/0.
- consume = (count != 0) & ~stall & ~redirect_valid; it pops the head at the clock edge.
- issue: `req_addr` <= `pc`, `pc` <= `pc`+4, state <= BUSY.
- IDLE: on redirect, flush the queue and issue at `redirect_pc`. Otherwise issue when (count − consume) < 2, else stay IDLE.
- BUSY, ack, no redirect: push {`req_addr`+4, `imem_rdata`}. Let occupancy = count + 1 − consume. If occupancy < 2, issue at once (back-to-back); else go to IDLE.
- BUSY, no ack: hold. Stall never withdraws a request.
- BUSY, redirect with ack: discard data, flush the queue, issue at `redirect_pc` (stay BUSY).
- BUSY, redirect without ack: flush the queue, `pc` <= `redirect_pc`, go to DROP.
- DROP: on ack, discard data and issue at `pc`. A further redirect updates `pc` and stays in DROP, or issues at the new target if ack arrives the same cycle.
- Redirect has priority over stall and consume. The queue never exceeds 2; overflow is a design error (assert).
- PC arithmetic is modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (async): state=IDLE, `pc`=`RESET_PC`, `req_addr`=`RESET_PC`, count=0. Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_inst`=`NOP`, `if_pc4`=0.
- First edge after reset release: issue, so `imem_req`=1 in cycle 1 with addr `RESET_PC`.
- Zero-wait memory (ack in the same cycle as req): an instruction is visible on `if_inst` the cycle after ack. Sustained throughput is 1 instruction/cycle with `stall`=0.
- Ack latency L cycles costs L−1 cycles per instruction; when the queue is empty, IF/ID captures `NOP` bubbles.
- Stall: outputs frozen; the queue fills to 2, after which `imem_req` deasserts once the outstanding fetch completes.
- Redirect: wrong-path bubble on `if_inst` in the redirect cycle. Target request goes out the next cycle, or after the dropped ack.

## Test plan
- Reset, `RESET_PC`=0, zero-wait memory returning `imem_rdata`=addr|0xA000_0000 -> cycle 1 req addr 0; from cycle 2 `if_pc4`=4,8,12… each cycle, `if_inst`=0xA000_0000, 0xA000_0004…
- Steady stream, `stall`=1 for 4 cycles -> `if_inst` held, `imem_req` low after queue=2; on release the next values continue with no skip or duplicate.
- Ack latency 3, redirect to 0x100 while addr 0x8 pending -> `if_inst`=`NOP` in the redirect cycle; 0x8 data never presented; next req addr 0x100; first delivered `if_pc4`=0x104.
- Redirect to 0x200 in the same cycle as ack -> data dropped, req addr 0x200 next cycle, no DROP entry; redirect with `stall`=1 and queue=2 -> queue flushed, redirect wins.
- PC wrap: `redirect_pc`=0xFFFF_FFFC -> `if_pc4`=0, next req addr 0.
- `clrn` pulsed low mid-request with queue=1 -> immediate `imem_req`=0, `if_inst`=`NOP`, `if_pc4`=0; restart at `RESET_PC`.
